rv_iommu_ddtc_gen2: RTL and testbench

- Parametrised, fully associative device-directory-table cache (DDTC) for the IOMMU translation front end.
- Caches packed device-context payloads, tagged by device_id.
- Provides three independent valid/ready ports: lookup with a registered 1-cycle response, fill, and flush (global or per-device).
- Also provides true-LRU replacement, duplicate-free fill and saturating hit/miss statistics.

---
 rtl/rv_iommu_pkg.sv | 29 ++
 rtl/rv_iommu_lru_ages.sv | 48 ++++
 rtl/rv_iommu_ddtc_gen2.sv | 149 ++++++++++++++
 tb/tb_rv_iommu_ddtc_gen2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iommu_pkg.sv
// Shared IOMMU types: device-id width and the packed device-context layout
// that the DDTC stores as an opaque payload.
package rv_iommu_pkg;

    localparam int DEVICE_ID_W = 24;

    typedef struct packed {
        logic [221:0] rsvd;
        logic [51:0]  msi_pattern;
        logic [51:0]  msi_mask;
        logic [43:0]  msiptp_ppn;
        logic [3:0]   msiptp_mode;
        logic [19:0]  pscid;
        logic [43:0]  fsc_ppn;
        logic [3:0]   fsc_mode;
        logic [43:0]  iohgatp_ppn;
        logic [15:0]  iohgatp_gscid;
        logic [3:0]   iohgatp_mode;
        logic         prpr;
        logic         pdtv;
        logic         dtf;
        logic         t2gpa;
        logic         en_pri;
        logic         en_ats;
    } dc_cache_t;

    localparam int DC_W = $bits(dc_cache_t);

endpackage

// File: rtl/rv_iommu_lru_ages.sv
// True-LRU age permutation: age DEPTH-1 is MRU, age 0 is the victim.
// Promoting entry k decrements every age above age[k].
module rv_iommu_lru_ages #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             promote_i,
    input  logic [IDX_W-1:0] promote_idx_i,
    output logic [IDX_W-1:0] victim_idx_o
);

    logic [IDX_W-1:0] age_q [DEPTH];
    logic [IDX_W-1:0] age_k;
    logic             ages_ok;

    assign age_k = age_q[promote_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= IDX_W'(i);
        end else if (promote_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == promote_idx_i)
                    age_q[i] <= IDX_W'(DEPTH - 1);
                else if (age_q[i] > age_k)
                    age_q[i] <= age_q[i] - IDX_W'(1);
            end
        end
    end

    always_comb begin
        victim_idx_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (age_q[i] == '0) victim_idx_o = IDX_W'(i);
    end

    always_comb begin
        ages_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            for (int j = i + 1; j < DEPTH; j++)
                if (age_q[i] == age_q[j]) ages_ok = 1'b0;
    end

    a_ages_unique: assert property (@(posedge clk) disable iff (!rst_n) ages_ok);

endmodule

// File: rtl/rv_iommu_ddtc_gen2.sv
// Fully associative device-directory-table cache with lookup, fill and
// flush ports (flush > fill > lookup), true-LRU and saturating stats.
module rv_iommu_ddtc_gen2 import rv_iommu_pkg::*; #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = DEVICE_ID_W,
    parameter int DATA_W = DC_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lkup_valid_i,
    output logic              lkup_ready_o,
    input  logic [TAG_W-1:0]  lkup_device_id_i,
    output logic              lkup_rsp_valid_o,
    output logic              lkup_hit_o,
    output logic [DATA_W-1:0] lkup_data_o,
    input  logic              fill_valid_i,
    output logic              fill_ready_o,
    input  logic [TAG_W-1:0]  fill_device_id_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              flush_valid_i,
    output logic              flush_ready_o,
    input  logic              flush_all_i,
    input  logic [TAG_W-1:0]  flush_device_id_i,
    output logic              flush_done_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic flush_fire, fill_fire, lkup_fire;
    logic [DEPTH-1:0] lkup_match, fill_match, flush_match;
    logic lkup_hit, fill_hit, has_free;
    logic [IW-1:0] lkup_idx, fill_idx, free_idx;
    logic [IW-1:0] lru_idx, victim_idx, promote_idx;
    logic promote;

    logic              rsp_valid_q, rsp_hit_q, done_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    assign flush_ready_o = rst_n;
    assign fill_ready_o  = rst_n & ~flush_valid_i;
    assign lkup_ready_o  = rst_n & ~flush_valid_i & ~fill_valid_i;

    assign flush_fire = flush_valid_i & flush_ready_o;
    assign fill_fire  = fill_valid_i & fill_ready_o;
    assign lkup_fire  = lkup_valid_i & lkup_ready_o;

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        lkup_match  = '0;
        fill_match  = '0;
        flush_match = '0;
        lkup_idx    = '0;
        fill_idx    = '0;
        free_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            lkup_match[i]  = valid_q[i] && (tag_q[i] == lkup_device_id_i);
            fill_match[i]  = valid_q[i] && (tag_q[i] == fill_device_id_i);
            flush_match[i] = flush_all_i ||
                             (valid_q[i] && (tag_q[i] == flush_device_id_i));
            if (lkup_match[i]) lkup_idx = IW'(i);
            if (fill_match[i]) fill_idx = IW'(i);
            if (!valid_q[i])   free_idx = IW'(i);
        end
    end

    assign lkup_hit = |lkup_match;
    assign fill_hit = |fill_match;
    assign has_free = ~&valid_q;

    assign victim_idx  = fill_hit ? fill_idx : (has_free ? free_idx : lru_idx);
    assign promote     = fill_fire | (lkup_fire & lkup_hit);
    assign promote_idx = fill_fire ? victim_idx : lkup_idx;

    rv_iommu_lru_ages #(
        .DEPTH (DEPTH),
        .IDX_W (IW)
    ) u_ages (
        .clk           (clk),
        .rst_n         (rst_n),
        .promote_i     (promote),
        .promote_idx_i (promote_idx),
        .victim_idx_o  (lru_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (flush_fire)
            valid_q <= valid_q & ~flush_match;
        else if (fill_fire)
            valid_q[victim_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill_fire) begin
            tag_q[victim_idx]  <= fill_device_id_i;
            data_q[victim_idx] <= fill_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= lkup_fire;
            rsp_hit_q   <= lkup_fire & lkup_hit;
            rsp_data_q  <= (lkup_fire & lkup_hit) ? data_q[lkup_idx] : '0;
            done_q      <= flush_fire;
            if (lkup_fire & lkup_hit & ~&hit_cnt_q)
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (lkup_fire & ~lkup_hit & ~&miss_cnt_q)
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign lkup_rsp_valid_o = rsp_valid_q;
    assign lkup_hit_o       = rsp_hit_q;
    assign lkup_data_o      = rsp_data_q;
    assign flush_done_o     = done_q;
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;

    logic tags_ok;
    always_comb begin
        tags_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            for (int j = i + 1; j < DEPTH; j++)
                if (valid_q[i] && valid_q[j] && tag_q[i] == tag_q[j])
                    tags_ok = 1'b0;
    end

    a_tag_unique: assert property (@(posedge clk) disable iff (!rst_n) tags_ok);
    a_hit_known: assert property (@(posedge clk) disable iff (!rst_n)
        lkup_rsp_valid_o |-> !$isunknown(lkup_hit_o));

endmodule

// File: tb/tb_rv_iommu_ddtc_gen2.sv
// Randomised scoreboard bench for rv_iommu_ddtc_gen2 (DEPTH=4) with a
// recency-list reference model and a CNT_W=2 twin for saturation.
module tb_rv_iommu_ddtc_gen2;

    localparam int D  = 4;
    localparam int TW = 24;
    localparam int DW = 512;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          lkup_valid, fill_valid, flush_valid, flush_all;
    logic [TW-1:0] lkup_id, fill_id, flush_id;
    logic [DW-1:0] fill_data;

    logic          lkup_ready, fill_ready, flush_ready;
    logic          rsp_valid, rsp_hit, flush_done;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] hit_cnt, miss_cnt;

    logic          s_lkup_ready, s_fill_ready, s_flush_ready;
    logic          s_rsp_valid, s_rsp_hit, s_flush_done;
    logic [DW-1:0] s_rsp_data;
    logic [1:0]    s_hit_cnt, s_miss_cnt;

    rv_iommu_ddtc_gen2 #(.DEPTH(D), .TAG_W(TW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lkup_valid_i(lkup_valid), .lkup_ready_o(lkup_ready),
        .lkup_device_id_i(lkup_id),
        .lkup_rsp_valid_o(rsp_valid), .lkup_hit_o(rsp_hit),
        .lkup_data_o(rsp_data),
        .fill_valid_i(fill_valid), .fill_ready_o(fill_ready),
        .fill_device_id_i(fill_id), .fill_data_i(fill_data),
        .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
        .flush_all_i(flush_all), .flush_device_id_i(flush_id),
        .flush_done_o(flush_done),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    rv_iommu_ddtc_gen2 #(.DEPTH(D), .TAG_W(TW), .DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .lkup_valid_i(lkup_valid), .lkup_ready_o(s_lkup_ready),
        .lkup_device_id_i(lkup_id),
        .lkup_rsp_valid_o(s_rsp_valid), .lkup_hit_o(s_rsp_hit),
        .lkup_data_o(s_rsp_data),
        .fill_valid_i(fill_valid), .fill_ready_o(s_fill_ready),
        .fill_device_id_i(fill_id), .fill_data_i(fill_data),
        .flush_valid_i(flush_valid), .flush_ready_o(s_flush_ready),
        .flush_all_i(flush_all), .flush_device_id_i(flush_id),
        .flush_done_o(s_flush_done),
        .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int unsigned   last;
    } ent_t;

    typedef struct {
        int            due;
        logic          hit;
        logic [DW-1:0] data;
        int unsigned   nh;
        int unsigned   nm;
    } exp_t;

    ent_t        cache[$];
    exp_t        rq[$];
    int          dq[$];
    int unsigned now_t, m_hit, m_miss;
    int          cyc, nerr, nchk;
    bit          in_rst;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [DW-1:0] a,
                       input logic [DW-1:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    function automatic logic [1:0] sat3(input int unsigned v);
        return (v > 3) ? 2'd3 : v[1:0];
    endfunction

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic m_flush(input bit fa, input logic [TW-1:0] id);
        dq.push_back(cyc + 1);
        for (int i = cache.size() - 1; i >= 0; i--)
            if (fa || cache[i].tag == id) cache.delete(i);
    endtask

    task automatic m_fill(input logic [TW-1:0] id, input logic [DW-1:0] d);
        int lru;
        now_t++;
        foreach (cache[i]) begin
            if (cache[i].tag == id) begin
                cache[i].data = d;
                cache[i].last = now_t;
                return;
            end
        end
        if (cache.size() < D) begin
            cache.push_back('{tag: id, data: d, last: now_t});
        end else begin
            lru = 0;
            foreach (cache[i]) if (cache[i].last < cache[lru].last) lru = i;
            cache[lru] = '{tag: id, data: d, last: now_t};
        end
    endtask

    task automatic m_lookup(input logic [TW-1:0] id);
        now_t++;
        foreach (cache[i]) begin
            if (cache[i].tag == id) begin
                cache[i].last = now_t;
                m_hit++;
                rq.push_back('{due: cyc + 1, hit: 1'b1, data: cache[i].data,
                               nh: m_hit, nm: m_miss});
                return;
            end
        end
        m_miss++;
        rq.push_back('{due: cyc + 1, hit: 1'b0, data: '0, nh: m_hit, nm: m_miss});
    endtask

    task automatic step(input bit fv, input bit fa, input logic [TW-1:0] fid,
                        input bit iv, input logic [TW-1:0] iid,
                        input logic [DW-1:0] idata,
                        input bit lv, input logic [TW-1:0] lid);
        @(posedge clk);
        #1;
        flush_valid = fv;
        flush_all   = fa;
        flush_id    = fid;
        fill_valid  = iv;
        fill_id     = iid;
        fill_data   = idata;
        lkup_valid  = lv;
        lkup_id     = lid;
        #1;
        chk("flush_ready", DW'(flush_ready), DW'(1'b1));
        chk("fill_ready", DW'(fill_ready), DW'(!fv));
        chk("lkup_ready", DW'(lkup_ready), DW'(!fv && !iv));
        if (fv)      m_flush(fa, fid);
        else if (iv) m_fill(iid, idata);
        else if (lv) m_lookup(lid);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic lookup(input logic [TW-1:0] id);
        step(0, 0, '0, 0, '0, '0, 1, id);
    endtask

    task automatic fill(input logic [TW-1:0] id, input logic [DW-1:0] d);
        step(0, 0, '0, 1, id, d, 0, '0);
    endtask

    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (!in_rst) begin
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
            ev = rq.size() > 0 && rq[0].due == cyc;
            chk("rsp_valid", DW'(rsp_valid), DW'(ev));
            if (ev) begin
                e = rq.pop_front();
                chk("rsp_hit", DW'(rsp_hit), DW'(e.hit));
                chk("rsp_data", rsp_data, e.data);
                chk("hit_cnt", DW'(hit_cnt), DW'(e.nh));
                chk("miss_cnt", DW'(miss_cnt), DW'(e.nm));
                chk("hit_cnt_sat", DW'(s_hit_cnt), DW'(sat3(e.nh)));
                chk("miss_cnt_sat", DW'(s_miss_cnt), DW'(sat3(e.nm)));
            end
            while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
            ev = dq.size() > 0 && dq[0] == cyc;
            chk("flush_done", DW'(flush_done), DW'(ev));
            if (ev) void'(dq.pop_front());
        end
    end

    initial begin
        bit fv, fa, iv, lv;
        in_rst      = 1'b1;
        lkup_valid  = 1'b0;
        fill_valid  = 1'b0;
        flush_valid = 1'b0;
        flush_all   = 1'b0;
        lkup_id     = '0;
        fill_id     = '0;
        flush_id    = '0;
        fill_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_rsp_hit", DW'(rsp_hit), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_flush_ready", DW'(flush_ready), '0);
        chk("rst_fill_ready", DW'(fill_ready), '0);
        chk("rst_lkup_ready", DW'(lkup_ready), '0);
        chk("rst_flush_done", DW'(flush_done), '0);
        chk("rst_hit_cnt", DW'(hit_cnt), '0);
        chk("rst_miss_cnt", DW'(miss_cnt), '0);
        rst_n  = 1'b1;
        in_rst = 1'b0;

        lookup(24'h000123);
        fill(24'h10, DW'('hA0));
        fill(24'h11, DW'('hA1));
        fill(24'h12, DW'('hA2));
        fill(24'h13, DW'('hA3));
        lookup(24'h12);
        lookup(24'h10);
        fill(24'h14, DW'('hA4));
        lookup(24'h11);
        lookup(24'h10);
        fill(24'h12, DW'('hBB));
        lookup(24'h12);
        lookup(24'h10);
        lookup(24'h13);
        lookup(24'h14);

        step(1, 0, 24'h13, 1, 24'h15, DW'('hCC), 1, 24'h13);
        step(0, 0, '0, 1, 24'h15, DW'('hCC), 1, 24'h13);
        lookup(24'h13);
        lookup(24'h15);

        step(1, 1, '0, 0, '0, '0, 0, '0);
        step(1, 0, 24'h15, 0, '0, '0, 0, '0);
        lookup(24'h10);
        lookup(24'h12);
        lookup(24'h14);
        lookup(24'h15);
        idle();

        repeat (500) begin
            fv = ($urandom_range(0, 9) == 0);
            fa = ($urandom_range(0, 3) == 0);
            iv = ($urandom_range(0, 2) == 0);
            lv = ($urandom_range(0, 1) == 1);
            step(fv, fa, TW'($urandom_range(0, 7)),
                 iv, TW'($urandom_range(0, 7)), rnd512(),
                 lv, TW'($urandom_range(0, 7)));
        end
        idle();
        idle();

        fill(24'h20, DW'('hD0));
        lookup(24'h20);
        @(posedge clk);
        #1;
        lkup_valid = 1'b0;
        chk("pre_rst_rsp_valid", DW'(rsp_valid), DW'(1'b1));
        in_rst = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", DW'(rsp_valid), '0);
        chk("mid_rst_hit_cnt", DW'(hit_cnt), '0);
        chk("mid_rst_miss_cnt", DW'(miss_cnt), '0);
        rq.delete();
        dq.delete();
        cache.delete();
        m_hit  = 0;
        m_miss = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        in_rst = 1'b0;
        lookup(24'h20);
        idle();
        idle();

        chk("rsp_queue_drained", DW'(rq.size()), '0);
        chk("done_queue_drained", DW'(dq.size()), '0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
